timestamp_capture: RTL and testbench

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_pkg.sv | 33 +++
 rtl/ts_fifo.sv | 79 +++++++
 rtl/timestamp_capture.sv | 123 ++++++++++++
 tb/tb_timestamp_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timestamp_pkg
//  Purpose  : Shared widths, FIFO entry layout and interval helper for the
//             timestamp capture block.
//  Revision : 1.0  initial release
// ============================================================================
package timestamp_pkg;

  // Width of the free-running counter and of every captured timestamp.
  localparam int CNT_W  = 32;
  // Width of the saturating dropped-event counter.
  localparam int DROP_W = 8;

  // One FIFO entry: captured count, interval to the previous accepted
  // capture, and a flag marking the first capture after reset.
  typedef struct packed {
    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] delta;
    logic             first;
  } ts_entry_t;

  // Modulo-2^CNT_W interval; unsigned subtraction wraps naturally, so a
  // counter rollover between the two samples still gives the small interval.
  function automatic logic [CNT_W-1:0] ts_interval(
    input logic [CNT_W-1:0] now_ts,
    input logic [CNT_W-1:0] prev_ts
  );
    return now_ts - prev_ts;
  endfunction

endpackage : timestamp_pkg
`default_nettype wire

// File: rtl/ts_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ts_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO of timestamp entries.
//             The head entry is visible on rdata whenever the FIFO is
//             non-empty and reads as all-zero when empty.
//  Revision : 1.0  initial release
// ============================================================================
module ts_fifo
  import timestamp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ts_entry_t                wdata,
  input  logic                     pop,
  output ts_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);

  ts_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign level = count;

  // A pop on an empty FIFO is meaningless; a push into a full FIFO is only
  // legal when the head leaves at the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head entry falls through; masked to zero so an empty FIFO reads as 0.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule : ts_fifo
`default_nettype wire

// File: rtl/timestamp_capture.sv
`default_nettype none
// ============================================================================
//  Module   : timestamp_capture
//  Purpose  : Captures the free-running counter on each rising edge of an
//             event line, computes the interval to the previous accepted
//             capture, and queues the result in a FWFT FIFO. Events that
//             find the FIFO full are dropped, flagged and counted.
//  Revision : 1.0  initial release
// ============================================================================
module timestamp_capture
  import timestamp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     event_in,
  input  logic                     enable,
  input  logic                     clr_ovf,
  output logic [CNT_W-1:0]         ts_data,
  output logic [CNT_W-1:0]         ts_delta,
  output logic                     ts_first,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic             event_q;
  logic             event_det;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             first_pending;
  logic [CNT_W-1:0] prev_ts;
  ts_entry_t        wr_entry;
  ts_entry_t        head;

  // Rising-edge detect. event_q tracks event_in regardless of enable, so a
  // line that rose while disabled does not fire once enable goes high.
  assign event_det = event_in & ~event_q & enable;

  // Consumer handshake; only a real pop when the FIFO holds something.
  assign pop = ts_valid & ts_ready;

  // Accept unless full with no simultaneous pop freeing a slot.
  assign accept = event_det & (~fifo_full | pop);
  assign drop   = event_det & fifo_full & ~pop;

  // Entry being written this cycle.
  always_comb begin
    wr_entry       = '0;
    wr_entry.ts    = count_in;
    wr_entry.first = first_pending;
    wr_entry.delta = first_pending ? '0 : ts_interval(count_in, prev_ts);
  end

  // Event line history; loads 1 in reset so a line held high across reset
  // release is not seen as a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= 1'b1;
    end else begin
      event_q <= event_in;
    end
  end

  // Reference for interval computation, advanced only by accepted events.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ts       <= '0;
      first_pending <= 1'b1;
    end else if (accept) begin
      prev_ts       <= count_in;
      first_pending <= 1'b0;
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop coinciding
  // with a clear wins, leaving exactly that one drop recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      ovf      <= drop;
      drop_cnt <= drop ? DROP_ONE : '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + DROP_ONE;
      end
    end
  end

  ts_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign ts_valid = ~fifo_empty;
  assign ts_data  = head.ts;
  assign ts_delta = head.delta;
  assign ts_first = head.first;

endmodule : timestamp_capture
`default_nettype wire

// File: tb/tb_timestamp_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timestamp_capture
//  Purpose  : Scoreboard bench for timestamp_capture with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timestamp_capture;
  import timestamp_pkg::*;

  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT_W-1:0]  count_in;
  logic              event_in;
  logic              enable;
  logic              clr_ovf;
  logic [CNT_W-1:0]  ts_data;
  logic [CNT_W-1:0]  ts_delta;
  logic              ts_first;
  logic              ts_valid;
  logic              ts_ready;
  logic [$clog2(DEPTH):0] level;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  ts_entry_t exp_q[$];

  timestamp_capture #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .event_in (event_in),
    .enable   (enable),
    .clr_ovf  (clr_ovf),
    .ts_data  (ts_data),
    .ts_delta (ts_delta),
    .ts_first (ts_first),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_entry(input logic [31:0] ts, input logic [31:0] d, input logic f);
    ts_entry_t e;
    e.ts = ts; e.delta = d; e.first = f;
    exp_q.push_back(e);
  endtask

  // One-cycle pulse on event_in with the given counter value.
  task automatic fire(input logic [31:0] c);
    count_in = c;
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
  endtask

  // Hold ready high until the FIFO empties, bounded.
  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    ts_ready = 1'b1;
    while (level != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    ts_ready = 1'b0;
    if (level != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: level=%0d expected=0", level);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready
  // are both high at the falling edge; compare the head to the scoreboard.
  always @(negedge clk) begin
    if (!rst && ts_valid && ts_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry: ts=0x%08h delta=0x%08h first=%0d expected=none",
                 ts_data, ts_delta, ts_first);
      end else begin
        ts_entry_t e;
        e = exp_q.pop_front();
        check("pop_ts",    ts_data,         e.ts);
        check("pop_delta", ts_delta,        e.delta);
        check("pop_first", 32'(ts_first),   32'(e.first));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; count_in = '0; event_in = 1'b0; enable = 1'b1;
    clr_ovf = 1'b0; ts_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_level",  32'(level),    0);
    check("rst_valid",  32'(ts_valid), 0);
    check("rst_ovf",    32'(ovf),      0);
    check("rst_drop",   32'(drop_cnt), 0);
    check("rst_data",   ts_data,       0);
    check("rst_delta",  ts_delta,      0);
    check("rst_first",  32'(ts_first), 0);

    // First capture and a plain interval
    ts_ready = 1'b1;
    expect_entry(100, 0, 1'b1);   fire(100);
    expect_entry(250, 150, 1'b0); fire(250);
    // Counter wrap
    expect_entry(32'hFFFF_FFF0, 32'hFFFF_FEF6, 1'b0); fire(32'hFFFF_FFF0);
    expect_entry(32'h0000_0010, 32'h0000_0020, 1'b0); fire(32'h0000_0010);
    tick(2);
    ts_ready = 1'b0;
    check("empty_after_basic", 32'(level), 0);

    // Overflow: 10 events, 8 accepted, 2 dropped
    for (int i = 0; i < 10; i++) begin
      if (i == 0)     expect_entry(1000, 984, 1'b0);
      else if (i < 8) expect_entry(32'(1000 + 10*i), 10, 1'b0);
      fire(32'(1000 + 10*i));
    end
    check("ovf_level", 32'(level),    8);
    check("ovf_flag",  32'(ovf),      1);
    check("ovf_drops", 32'(drop_cnt), 2);
    check("stall_data", ts_data, 1000);
    tick(3);
    check("stall_data_hold",  ts_data,  1000);
    check("stall_delta_hold", ts_delta, 984);
    drain(20);
    // Dropped events must not move the interval reference (last accepted 1070)
    ts_ready = 1'b1;
    expect_entry(2000, 930, 1'b0); fire(2000);
    tick();
    ts_ready = 1'b0;

    // Clear overflow
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf_flag",  32'(ovf),      0);
    check("clr_ovf_drops", 32'(drop_cnt), 0);

    // Full FIFO, event and pop at the same edge
    for (int i = 0; i < 8; i++) begin
      expect_entry(32'(3000 + i), (i == 0) ? 1000 : 1, 1'b0);
      fire(32'(3000 + i));
    end
    check("full_level", 32'(level), 8);
    expect_entry(3100, 93, 1'b0);
    count_in = 3100; event_in = 1'b1; ts_ready = 1'b1;
    tick();
    event_in = 1'b0; ts_ready = 1'b0;
    check("fullpop_level", 32'(level),    8);
    check("fullpop_ovf",   32'(ovf),      0);
    check("fullpop_drops", 32'(drop_cnt), 0);
    tick();
    drain(20);

    // Held-high line gives one event; rise while disabled gives none
    count_in = 4000; event_in = 1'b1;
    expect_entry(4000, 900, 1'b0);
    tick(20);
    check("held_level", 32'(level), 1);
    event_in = 1'b0; enable = 1'b0; tick();
    count_in = 4500; event_in = 1'b1; tick(2);
    enable = 1'b1; tick(3);
    check("disabled_level", 32'(level), 1);
    event_in = 1'b0; tick();
    drain(10);

    // Drops, drop coinciding with clear, and saturation
    for (int i = 0; i < 8; i++) begin
      expect_entry(32'(5000 + i), (i == 0) ? 1000 : 1, 1'b0);
      fire(32'(5000 + i));
    end
    fire(5100); fire(5101);
    check("drop2_ovf",   32'(ovf),      1);
    check("drop2_count", 32'(drop_cnt), 2);
    count_in = 5102; event_in = 1'b1; clr_ovf = 1'b1;
    tick();
    event_in = 1'b0; clr_ovf = 1'b0;
    tick();
    check("clrdrop_ovf",   32'(ovf),      1);
    check("clrdrop_count", 32'(drop_cnt), 1);
    for (int i = 0; i < 260; i++) fire(32'(6000 + i));
    check("sat_count", 32'(drop_cnt), 255);
    check("sat_level", 32'(level),    8);

    // Pop three, then reset with level 5 and the event line high
    ts_ready = 1'b1; tick(3); ts_ready = 1'b0;
    check("pre_rst_level", 32'(level), 5);
    tick();
    exp_q.delete();
    event_in = 1'b1; count_in = 7000; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("post_rst_level", 32'(level),    0);
    check("post_rst_valid", 32'(ts_valid), 0);
    check("post_rst_ovf",   32'(ovf),      0);
    check("post_rst_drops", 32'(drop_cnt), 0);
    check("post_rst_data",  ts_data,       0);
    event_in = 1'b0; tick();
    ts_ready = 1'b1;
    expect_entry(7777, 0, 1'b1); fire(7777);
    tick(2);
    ts_ready = 1'b0;

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_timestamp_capture
`default_nettype wire
